// File: rtl/game_round_scheduler.sv
// Round sequencer for the counter game: replays queued {mode, load, value, len} commands onto the
// counter control bus, parks the counter between sessions and tallies WINNER/LOSER events.
module game_round_scheduler #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned LEN_W      = 8,
  parameter logic [1:0]  PARK_VALUE = 2'b01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic             cmd_load,
  input  logic [1:0]       cmd_value,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             start,
  input  logic             abort,
  output logic [1:0]       control,
  output logic             INIT,
  output logic [1:0]       load_value,
  input  logic             WINNER,
  input  logic             LOSER,
  input  logic             GAMEOVER,
  input  logic [1:0]       WHO,
  output logic             busy,
  output logic             done,
  output logic [1:0]       final_who,
  output logic [3:0]       win_events,
  output logic [3:0]       lose_events
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned ENT_W = 5 + LEN_W;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       cur_mode_q, cur_mode_d;
  logic [1:0]       cur_value_q, cur_value_d;
  logic [LEN_W-1:0] cur_len_q, cur_len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [3:0]       win_q, win_d;
  logic [3:0]       lose_q, lose_d;
  logic [1:0]       who_q, who_d;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             full, empty, push, pop, flush;
  logic [ENT_W-1:0] head;
  logic [1:0]       head_mode, head_value;
  logic             head_load;
  logic [LEN_W-1:0] head_len, head_len_nz, cur_len_nz;

  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = ~full;
  // Readiness comes from the registered count, so a pop cannot free a slot for this cycle's push.
  assign push      = cmd_valid & ~full;

  assign head = mem_q[rd_ptr_q];
  assign {head_mode, head_load, head_value, head_len} = head;
  assign head_len_nz = (head_len == '0) ? LEN_W'(1) : head_len;
  assign cur_len_nz  = (cur_len_q == '0) ? LEN_W'(1) : cur_len_q;

  always_comb begin
    state_d     = state_q;
    cur_mode_d  = cur_mode_q;
    cur_value_d = cur_value_q;
    cur_len_d   = cur_len_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    lose_d      = lose_q;
    who_d       = who_q;
    pop         = 1'b0;
    flush       = 1'b0;

    if (state_q == StLoad || state_q == StRun) begin
      if (WINNER && win_q != 4'hF) win_d = win_q + 4'd1;
      if (LOSER && lose_q != 4'hF) lose_d = lose_q + 4'd1;
    end

    case (state_q)
      StIdle: begin
        if (start && !empty) begin
          pop    = 1'b1;
          win_d  = '0;
          lose_d = '0;
        end
      end
      StLoad: begin
        if (GAMEOVER) begin
          flush   = 1'b1;
          who_d   = WHO;
          state_d = StDone;
        end else if (abort) begin
          flush   = 1'b1;
          who_d   = 2'b00;
          state_d = StDone;
        end else begin
          cnt_d   = cur_len_nz;
          state_d = StRun;
        end
      end
      StRun: begin
        if (GAMEOVER) begin
          flush   = 1'b1;
          who_d   = WHO;
          state_d = StDone;
        end else if (abort) begin
          flush   = 1'b1;
          who_d   = 2'b00;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            if (!empty) begin
              pop = 1'b1;
            end else begin
              who_d   = 2'b00;
              state_d = StDone;
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Shared pop path: start from idle and back-to-back advance both land here.
    if (pop) begin
      cur_mode_d  = head_mode;
      cur_value_d = head_value;
      cur_len_d   = head_len;
      if (head_load) begin
        state_d = StLoad;
      end else begin
        state_d = StRun;
        cnt_d   = head_len_nz;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop) count_d = count_q + (PTR_W+1)'(1);
      else if (!push && pop) count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= {cmd_mode, cmd_load, cmd_value, cmd_len};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_mode_q  <= '0;
      cur_value_q <= '0;
      cur_len_q   <= '0;
      cnt_q       <= '0;
      win_q       <= '0;
      lose_q      <= '0;
      who_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_mode_q  <= cur_mode_d;
      cur_value_q <= cur_value_d;
      cur_len_q   <= cur_len_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
      who_q       <= who_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_comb begin
    control    = 2'b00;
    INIT       = 1'b1;
    load_value = PARK_VALUE;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      StLoad: begin
        control    = cur_mode_q;
        load_value = cur_value_q;
        busy       = 1'b1;
      end
      StRun: begin
        control    = cur_mode_q;
        INIT       = 1'b0;
        load_value = cur_value_q;
        busy       = 1'b1;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  assign final_who   = who_q;
  assign win_events  = win_q;
  assign lose_events = lose_q;

endmodule

// File: tb/tb_game_round_scheduler.sv
// Directed bench for game_round_scheduler: hand-computed expectations sampled 1ns after each edge.
module tb_game_round_scheduler;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic       cmd_load;
  logic [1:0] cmd_value;
  logic [7:0] cmd_len;
  logic       start;
  logic       abort;
  logic [1:0] control;
  logic       INIT;
  logic [1:0] load_value;
  logic       WINNER;
  logic       LOSER;
  logic       GAMEOVER;
  logic [1:0] WHO;
  logic       busy;
  logic       done;
  logic [1:0] final_who;
  logic [3:0] win_events;
  logic [3:0] lose_events;

  int n_checks = 0;
  int n_errors = 0;
  int n_busy;

  game_round_scheduler #(
    .DEPTH     (4),
    .LEN_W     (8),
    .PARK_VALUE(2'b01)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_load   (cmd_load),
    .cmd_value  (cmd_value),
    .cmd_len    (cmd_len),
    .start      (start),
    .abort      (abort),
    .control    (control),
    .INIT       (INIT),
    .load_value (load_value),
    .WINNER     (WINNER),
    .LOSER      (LOSER),
    .GAMEOVER   (GAMEOVER),
    .WHO        (WHO),
    .busy       (busy),
    .done       (done),
    .final_who  (final_who),
    .win_events (win_events),
    .lose_events(lose_events)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [1:0] mode, input logic load, input logic [1:0] value,
                          input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_load  = load;
    cmd_value = value;
    cmd_len   = len;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Bus snapshot: {control, INIT, load_value, busy, done}
  function automatic logic [6:0] bus();
    return {control, INIT, load_value, busy, done};
  endfunction

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = '0; cmd_load = 1'b0; cmd_value = '0;
    cmd_len = '0; start = 1'b0; abort = 1'b0; WINNER = 1'b0; LOSER = 1'b0;
    GAMEOVER = 1'b0; WHO = '0;

    // Reset
    step(); step();
    rst_n = 1'b1;
    check_eq("rst_bus", 32'(bus()), 32'({2'b00, 1'b1, 2'b01, 1'b0, 1'b0}));
    check_eq("rst_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_cnt", 32'({win_events, lose_events, final_who}), 32'd0);

    // Single command with load
    push_cmd(2'b01, 1'b1, 2'd2, 8'd3);
    do_start();
    check_eq("single_load", 32'(bus()), 32'({2'b01, 1'b1, 2'd2, 1'b1, 1'b0}));
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("single_run", 32'(bus()), 32'({2'b01, 1'b0, 2'd2, 1'b1, 1'b0}));
    end
    step();
    check_eq("single_done", 32'(bus()), 32'({2'b00, 1'b1, 2'b01, 1'b0, 1'b1}));
    step();
    check_eq("single_park", 32'(bus()), 32'({2'b00, 1'b1, 2'b01, 1'b0, 1'b0}));

    // Back-to-back, len=0 treated as 1
    push_cmd(2'b10, 1'b0, 2'd0, 8'd0);
    push_cmd(2'b11, 1'b1, 2'd3, 8'd2);
    do_start();
    check_eq("b2b_run_a", 32'(bus()), 32'({2'b10, 1'b0, 2'd0, 1'b1, 1'b0}));
    step();
    check_eq("b2b_load_b", 32'(bus()), 32'({2'b11, 1'b1, 2'd3, 1'b1, 1'b0}));
    step();
    check_eq("b2b_run_b1", 32'(bus()), 32'({2'b11, 1'b0, 2'd3, 1'b1, 1'b0}));
    step();
    check_eq("b2b_run_b2", 32'(bus()), 32'({2'b11, 1'b0, 2'd3, 1'b1, 1'b0}));
    step();
    check_eq("b2b_done", 32'(done), 32'd1);
    step();

    // Full queue: 5th push refused
    cmd_valid = 1'b1; cmd_load = 1'b0; cmd_value = 2'd0; cmd_len = 8'd1;
    for (int i = 0; i < 5; i++) begin
      check_eq("full_ready", 32'(cmd_ready), (i < 4) ? 32'd1 : 32'd0);
      cmd_mode = 2'(i % 3 + 1);
      if (i == 4) cmd_len = 8'd5;
      step();
    end
    cmd_valid = 1'b0;
    check_eq("full_ready_after", 32'(cmd_ready), 32'd0);
    do_start();
    check_eq("full_pop_ready", 32'(cmd_ready), 32'd1);
    n_busy = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (busy) n_busy++;
      step();
    end
    check_eq("full_done", 32'(done), 32'd1);
    check_eq("full_busy_cycles", 32'(n_busy), 32'd4);
    step();

    // GAMEOVER mid-command flushes the queue
    for (int i = 0; i < 3; i++) push_cmd(2'b01, 1'b0, 2'd1, 8'd10);
    do_start();
    step();
    GAMEOVER = 1'b1; WHO = 2'b10; abort = 1'b1;
    step();
    GAMEOVER = 1'b0; WHO = 2'b00; abort = 1'b0;
    check_eq("go_done", 32'({busy, done}), 32'b01);
    check_eq("go_who", 32'(final_who), 32'b10);
    check_eq("go_ready", 32'(cmd_ready), 32'd1);
    step();
    check_eq("go_park", 32'(bus()), 32'({2'b00, 1'b1, 2'b01, 1'b0, 1'b0}));
    do_start();
    check_eq("go_empty_start", 32'(busy), 32'd0);
    check_eq("go_who_hold", 32'(final_who), 32'b10);

    // Event saturation and abort
    push_cmd(2'b11, 1'b0, 2'd0, 8'd20);
    do_start();
    check_eq("ev_clear", 32'({win_events, lose_events}), 32'd0);
    WINNER = 1'b1; LOSER = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step();
      if (i == 4) check_eq("ev_five", 32'({win_events, lose_events}), 32'h55);
    end
    WINNER = 1'b0; LOSER = 1'b0;
    check_eq("ev_still_busy", 32'(busy), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("ab_done", 32'(done), 32'd1);
    check_eq("ab_events", 32'({win_events, lose_events}), 32'hFF);
    check_eq("ab_who", 32'(final_who), 32'd0);
    step();
    do_start();
    check_eq("ab_empty_start", 32'(busy), 32'd0);
    check_eq("ab_events_hold", 32'({win_events, lose_events}), 32'hFF);

    // Abort in idle is ignored
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("idle_abort", 32'({busy, done}), 32'd0);

    // Reset mid-session empties the queue
    push_cmd(2'b01, 1'b0, 2'd0, 8'd10);
    push_cmd(2'b10, 1'b0, 2'd0, 8'd10);
    do_start();
    step();
    rst_n = 1'b0;
    step();
    check_eq("mid_rst_bus", 32'(bus()), 32'({2'b00, 1'b1, 2'b01, 1'b0, 1'b0}));
    check_eq("mid_rst_cnt", 32'({win_events, lose_events, final_who}), 32'd0);
    rst_n = 1'b1;
    step();
    do_start();
    check_eq("mid_rst_empty", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
